// File: rtl/fetch_unit.sv
// Fetch stage: PC register, F/D pipeline latch, branch-redirect handling
// and a saturating misprediction counter. The resolved next PC from execute
// is compared against the prediction carried with that instruction; on a
// mismatch fetch is redirected and the decode latch is killed.
module fetch_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic        stall,
  input  logic        bp_taken,
  input  logic [11:0] bp_target,
  input  logic [31:0] imem_data,
  input  logic        ex_valid,
  input  logic [11:0] ex_pc,
  input  logic [11:0] ex_pred_next,
  input  logic [11:0] ex_correct_addr,
  output logic [11:0] pc_out,
  output logic [31:0] fd_insn,
  output logic [11:0] fd_pc,
  output logic [11:0] fd_pc_plus1,
  output logic [11:0] fd_pred_next,
  output logic        fd_valid,
  output logic        flush,
  output logic        bp_guessed_wrong,
  output logic [11:0] bp_original_pc,
  output logic [11:0] bp_correct_address,
  output logic [11:0] bp_next_pc,
  output logic [15:0] mispredict_count
);

  logic [11:0] pcPlus1;
  logic [11:0] predNext;
  logic        mispredict;

  // Next-PC prediction and redirect detection; 12-bit adds wrap naturally.
  always_comb begin
    pcPlus1    = pc_out + 12'd1;
    predNext   = bp_taken ? bp_target : pcPlus1;
    mispredict = ex_valid && (ex_correct_addr != ex_pred_next);
  end

  // Predictor update port and flush mirror the execute-stage resolution;
  // they are not gated by clear, consumers must qualify them.
  always_comb begin
    flush              = mispredict;
    bp_guessed_wrong   = mispredict;
    bp_original_pc     = ex_pc;
    bp_correct_address = ex_correct_addr;
    bp_next_pc         = ex_pc + 12'd1;
  end

  // PC register: clear, then redirect (overrides stall), then hold, then predict.
  always_ff @(posedge clock) begin
    if (clear)           pc_out <= 12'h000;
    else if (mispredict) pc_out <= ex_correct_addr;
    else if (!stall)     pc_out <= predNext;
  end

  // F/D latch: a redirect inserts a zeroed bubble even while stalled.
  always_ff @(posedge clock) begin
    if (clear || mispredict) begin
      fd_insn      <= 32'h0;
      fd_pc        <= 12'h000;
      fd_pc_plus1  <= 12'h000;
      fd_pred_next <= 12'h000;
      fd_valid     <= 1'b0;
    end else if (!stall) begin
      fd_insn      <= imem_data;
      fd_pc        <= pc_out;
      fd_pc_plus1  <= pcPlus1;
      fd_pred_next <= predNext;
      fd_valid     <= 1'b1;
    end
  end

  // Misprediction counter, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (clear)
      mispredict_count <= 16'h0000;
    else if (mispredict && (mispredict_count != 16'hFFFF))
      mispredict_count <= mispredict_count + 16'd1;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, predicted-taken,
// redirects (with stall, back-to-back), stall hold, PC wrap, clear
// priority and counter saturation.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        clear, stall, bp_taken, ex_valid;
  logic [11:0] bp_target, ex_pc, ex_pred_next, ex_correct_addr;
  logic [31:0] imem_data;
  logic [11:0] pc_out, fd_pc, fd_pc_plus1, fd_pred_next;
  logic [31:0] fd_insn;
  logic        fd_valid, flush, bp_guessed_wrong;
  logic [11:0] bp_original_pc, bp_correct_address, bp_next_pc;
  logic [15:0] mispredict_count;

  int vectors = 0;
  int errs    = 0;

  fetch_unit dut (
    .clock(clock), .clear(clear), .stall(stall), .bp_taken(bp_taken),
    .bp_target(bp_target), .imem_data(imem_data), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_pred_next(ex_pred_next), .ex_correct_addr(ex_correct_addr),
    .pc_out(pc_out), .fd_insn(fd_insn), .fd_pc(fd_pc), .fd_pc_plus1(fd_pc_plus1),
    .fd_pred_next(fd_pred_next), .fd_valid(fd_valid), .flush(flush),
    .bp_guessed_wrong(bp_guessed_wrong), .bp_original_pc(bp_original_pc),
    .bp_correct_address(bp_correct_address), .bp_next_pc(bp_next_pc),
    .mispredict_count(mispredict_count)
  );

  always #5 clock = ~clock;

  // Instruction memory model: word at address a is 0xA0000000 + a.
  always_comb imem_data = 32'hA000_0000 + {20'h0, pc_out};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; leave 1 time unit past the edge before returning.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic setEx(input logic v, input logic [11:0] pc, input logic [11:0] pn,
                       input logic [11:0] ca);
    ex_valid = v; ex_pc = pc; ex_pred_next = pn; ex_correct_addr = ca;
  endtask

  initial begin
    clear = 1'b1; stall = 1'b0; bp_taken = 1'b0; bp_target = 12'h000;
    setEx(1'b0, 12'h000, 12'h000, 12'h000);
    step();
    chk("rst_pc", {20'h0, pc_out}, 32'h000);
    chk("rst_fdvalid", {31'h0, fd_valid}, 32'h0);
    chk("rst_fdinsn", fd_insn, 32'h0);
    chk("rst_fdpc", {8'h0, fd_pc, fd_pc_plus1}, 32'h0);
    chk("rst_fdpn", {20'h0, fd_pred_next}, 32'h0);
    chk("rst_cnt", {16'h0, mispredict_count}, 32'h0);

    // Sequential fetch
    clear = 1'b0;
    step();
    chk("seq_pc1", {20'h0, pc_out}, 32'h001);
    chk("seq_fdpc0", {20'h0, fd_pc}, 32'h000);
    chk("seq_fdvalid", {31'h0, fd_valid}, 32'h1);
    chk("seq_fdinsn0", fd_insn, 32'hA000_0000);
    chk("seq_fdpn0", {20'h0, fd_pred_next}, 32'h001);
    step();
    chk("seq_pc2", {20'h0, pc_out}, 32'h002);
    chk("seq_fdpc1", {20'h0, fd_pc}, 32'h001);
    step();
    chk("seq_pc3", {20'h0, pc_out}, 32'h003);
    chk("seq_fdpn2", {20'h0, fd_pred_next}, 32'h003);
    step(); step();

    // Predicted taken at 0x005
    chk("tk_pre_pc", {20'h0, pc_out}, 32'h005);
    bp_taken = 1'b1; bp_target = 12'h040;
    step();
    bp_taken = 1'b0;
    chk("tk_pc", {20'h0, pc_out}, 32'h040);
    chk("tk_fdpc", {20'h0, fd_pc}, 32'h005);
    chk("tk_fdpn", {20'h0, fd_pred_next}, 32'h040);
    chk("tk_fdp1", {20'h0, fd_pc_plus1}, 32'h006);

    // Mispredict overriding stall
    stall = 1'b1;
    setEx(1'b1, 12'h010, 12'h011, 12'h080);
    #1;
    chk("mp_flush", {31'h0, flush}, 32'h1);
    chk("mp_gw", {31'h0, bp_guessed_wrong}, 32'h1);
    chk("mp_nextpc", {20'h0, bp_next_pc}, 32'h011);
    chk("mp_origpc", {20'h0, bp_original_pc}, 32'h010);
    chk("mp_corr", {20'h0, bp_correct_address}, 32'h080);
    step();
    stall = 1'b0;
    setEx(1'b0, 12'h010, 12'h011, 12'h080);
    chk("mp_pc", {20'h0, pc_out}, 32'h080);
    chk("mp_fdvalid", {31'h0, fd_valid}, 32'h0);
    chk("mp_fdinsn", fd_insn, 32'h0);
    chk("mp_fdpc", {20'h0, fd_pc}, 32'h000);
    chk("mp_cnt", {16'h0, mispredict_count}, 32'h1);
    step();
    chk("mp_resume_pc", {20'h0, pc_out}, 32'h081);
    chk("mp_resume_insn", fd_insn, 32'hA000_0080);
    chk("mp_resume_fdpc", {20'h0, fd_pc}, 32'h080);

    // Correct prediction, then mismatch with ex_valid low
    setEx(1'b1, 12'h122, 12'h123, 12'h123);
    #1;
    chk("ok_flush", {31'h0, flush}, 32'h0);
    chk("ok_gw", {31'h0, bp_guessed_wrong}, 32'h0);
    step();
    chk("ok_pc", {20'h0, pc_out}, 32'h082);
    chk("ok_cnt", {16'h0, mispredict_count}, 32'h1);
    setEx(1'b0, 12'h122, 12'h123, 12'h555);
    #1;
    chk("inv_flush", {31'h0, flush}, 32'h0);
    chk("inv_gw", {31'h0, bp_guessed_wrong}, 32'h0);
    step();
    chk("inv_pc", {20'h0, pc_out}, 32'h083);
    chk("inv_cnt", {16'h0, mispredict_count}, 32'h1);

    // Back-to-back mispredicts
    setEx(1'b1, 12'h100, 12'h201, 12'h200);
    step();
    chk("b2b_pc1", {20'h0, pc_out}, 32'h200);
    chk("b2b_cnt1", {16'h0, mispredict_count}, 32'h2);
    setEx(1'b1, 12'h101, 12'h102, 12'h300);
    step();
    chk("b2b_pc2", {20'h0, pc_out}, 32'h300);
    chk("b2b_cnt2", {16'h0, mispredict_count}, 32'h3);
    chk("b2b_fdvalid", {31'h0, fd_valid}, 32'h0);

    // Stall hold at 0x020 (redirect to 0x01F first so F/D holds real data)
    setEx(1'b1, 12'h000, 12'h001, 12'h01F);
    step();
    setEx(1'b0, 12'h000, 12'h000, 12'h000);
    step();
    chk("st_pre_pc", {20'h0, pc_out}, 32'h020);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_pc", {20'h0, pc_out}, 32'h020);
      chk("st_fdpc", {20'h0, fd_pc}, 32'h01F);
      chk("st_fdinsn", fd_insn, 32'hA000_001F);
      chk("st_fdpn", {20'h0, fd_pred_next, 8'h0, fd_pc_plus1}, 32'h0200_0020);
      chk("st_fdvalid", {31'h0, fd_valid}, 32'h1);
    end
    stall = 1'b0;
    step();
    chk("st_rel_pc", {20'h0, pc_out}, 32'h021);
    chk("st_rel_fdpc", {20'h0, fd_pc}, 32'h020);
    chk("st_rel_fdpn", {20'h0, fd_pred_next}, 32'h021);

    // PC wrap 0xFFF -> 0x000, and bp_next_pc wrap
    bp_taken = 1'b1; bp_target = 12'hFFF;
    step();
    bp_taken = 1'b0;
    chk("wr_pre_pc", {20'h0, pc_out}, 32'hFFF);
    step();
    chk("wr_pc", {20'h0, pc_out}, 32'h000);
    chk("wr_fdpc", {20'h0, fd_pc}, 32'hFFF);
    chk("wr_fdp1", {20'h0, fd_pc_plus1}, 32'h000);
    chk("wr_fdpn", {20'h0, fd_pred_next}, 32'h000);
    setEx(1'b0, 12'hFFF, 12'h000, 12'h000);
    #1;
    chk("wr_bpnext", {20'h0, bp_next_pc}, 32'h000);

    // Clear during stall and redirect
    step(); step();
    stall = 1'b1; clear = 1'b1;
    setEx(1'b1, 12'h050, 12'h051, 12'h400);
    #1;
    chk("clr_flush_comb", {31'h0, flush}, 32'h1);
    step();
    chk("clr_pc", {20'h0, pc_out}, 32'h000);
    chk("clr_fdvalid", {31'h0, fd_valid}, 32'h0);
    chk("clr_cnt", {16'h0, mispredict_count}, 32'h0);
    clear = 1'b0; stall = 1'b0;
    setEx(1'b0, 12'h000, 12'h000, 12'h000);
    step();
    chk("clr_rel_pc", {20'h0, pc_out}, 32'h001);
    chk("clr_rel_fdpc", {20'h0, fd_pc}, 32'h000);
    chk("clr_rel_insn", fd_insn, 32'hA000_0000);

    // Saturation: 65536 consecutive mispredicts
    setEx(1'b1, 12'h000, 12'h001, 12'h002);
    for (int i = 0; i < 65536; i++) begin
      step();
      if (i == 65533) chk("sat_fffe", {16'h0, mispredict_count}, 32'hFFFE);
    end
    chk("sat_ffff", {16'h0, mispredict_count}, 32'hFFFF);
    step();
    chk("sat_hold", {16'h0, mispredict_count}, 32'hFFFF);
    setEx(1'b0, 12'h000, 12'h000, 12'h000);
    clear = 1'b1;
    step();
    chk("sat_clr", {16'h0, mispredict_count}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clock  in  1  single clock; all state updates on rising edge.
REQ-002 clear  in  1  synchronous, active-high reset.
REQ-003 stall  in  1  hazard hold; freezes PC and F/D latch.
REQ-004 bp_taken  in  1  predictor direction for pc_out.
REQ-005 bp_target  in  12  predictor target for pc_out.
REQ-006 imem_data  in  32  instruction at pc_out, combinational, same cycle.
REQ-007 ex_valid  in  1  execute stage holds a real instruction.
REQ-008 ex_pc  in  12  fetch PC of execute-stage instruction.
REQ-009 ex_pred_next  in  12  predicted next PC carried with execute-stage instruction.
REQ-010 ex_correct_addr  in  12  resolved next PC from branch logic.
REQ-011 pc_out  out  12  current fetch PC; drives imem address and predictor read index.
REQ-012 fd_insn, fd_pc, fd_pc_plus1, fd_pred_next  out  32/12/12/12  F/D latch contents.
REQ-013 fd_valid  out  1  F/D latch holds a real instruction.
REQ-014 flush  out  1  kill decode-stage latch this cycle.
REQ-015 bp_guessed_wrong, bp_original_pc, bp_correct_address, bp_next_pc  out  1/12/12/12  predictor update port.
REQ-016 mispredict_count  out  16  saturating misprediction counter.

Function
REQ-017 The block SHALL compute pred_next = bp_taken ? bp_target : pc_out+1, with the +1 wrapping modulo 4096 (0xFFF+1 = 0x000).
REQ-018 The block SHALL assert mispredict = ex_valid AND (ex_correct_addr != ex_pred_next), combinationally.
REQ-019 bp_guessed_wrong and flush SHALL equal mispredict; bp_original_pc = ex_pc; bp_correct_address = ex_correct_addr; bp_next_pc = ex_pc+1 (mod 4096).
REQ-020 PC update priority SHALL be: clear -> 0x000; else mispredict -> ex_correct_addr; else stall -> hold; else pred_next.
REQ-021 F/D update priority SHALL be: clear -> zeros, fd_valid=0; else mispredict -> fd_insn=0 (nop), fd_valid=0, other fields don't-care but SHALL be zeroed; else stall -> hold all fields; else load imem_data, pc_out, pc_out+1, pred_next, fd_valid=1.
REQ-022 Mispredict SHALL override stall in the same cycle, for both PC and F/D.
REQ-023 Redirect latency: the cycle after mispredict, pc_out SHALL equal the corrected address and fetch from it; the corrected instruction reaches F/D one cycle later (one-cycle fetch bubble plus flushed decode).
REQ-024 mispredict_count SHALL increment by 1 on each cycle with mispredict=1 and saturate at 0xFFFF; clear SHALL take priority over increment.
REQ-025 Back-to-back mispredict cycles SHALL each redirect and each count once.
REQ-026 With ex_valid=0, no redirect, flush, predictor write or count SHALL occur regardless of other ex_* inputs.

Reset
REQ-027 The cycle after clear: pc_out=0x000, fd_valid=0, fd_insn=0, fd_pc=fd_pc_plus1=fd_pred_next=0, mispredict_count=0.
REQ-028 clear asserted mid-redirect or mid-stall SHALL win over both; the first fetch after release is from 0x000.
REQ-029 Combinational outputs (flush, bp_*) SHALL follow inputs during clear; downstream gating is the consumer's responsibility.

Verification
REQ-030 Sequential: clear 1 cycle, bp_taken=0, imem_data=0xA0000000+addr, no stall -> pc_out 0,1,2,3; fd_pc lags by 1; fd_pred_next = fd_pc+1; fd_valid=1 from second cycle.
REQ-031 Predicted taken: at pc_out=0x005 bp_taken=1, bp_target=0x040 -> next pc_out=0x040; fd_pred_next=0x040, fd_pc=0x005.
REQ-032 Mispredict with stall: ex_valid=1, ex_pc=0x010, ex_pred_next=0x011, ex_correct_addr=0x080, stall=1 -> flush=1, bp_guessed_wrong=1, bp_next_pc=0x011; next cycle pc_out=0x080, fd_valid=0, fd_insn=0, count+1.
REQ-033 Correct prediction: ex_valid=1, ex_pred_next=ex_correct_addr=0x123 -> flush=0, bp_guessed_wrong=0, no PC change, count unchanged; same mismatch with ex_valid=0 -> no effect.
REQ-034 Wrap and saturation: pc_out=0xFFF, bp_taken=0 -> next pc_out=0x000, fd_pc_plus1=0x000; force 65536 mispredicts -> count holds at 0xFFFF.
REQ-035 Stall hold: stall=1 for 3 cycles at pc_out=0x020 -> pc_out and all fd_* unchanged; release -> fetch resumes at 0x020's pred_next.
